// File: rtl/bus_pkg.sv
// Shared types for the memory bus arbiter: FSM states, grant encoding and
// a default-width view of one bus request.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_MASK_W = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    DATA
  } arb_state_t;

  typedef enum logic {
    GRANT_INSTR,
    GRANT_DATA
  } arb_grant_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] address;
    logic                  read;
    logic                  write;
    logic [BUS_MASK_W-1:0] mask;
    logic [BUS_DATA_W-1:0] write_value;
  } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is granted; last_grant only moves when a grant is taken.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_instr,
  input  logic       req_data,
  input  logic       update,
  output arb_grant_t grant,
  output logic       any_req
);

  arb_grant_t last_grant;

  // Pick the winner from the current requests and the last grant.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    grant   = GRANT_INSTR;
    any_req = req_instr | req_data;
    if (req_instr && req_data) begin
      grant = (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
    end else if (req_data) begin
      grant = GRANT_DATA;
    end
  end

  // Remember who won, so the other side wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      last_grant <= GRANT_INSTR;
    end else if (update && any_req) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between the instruction and data buses.
// Single outstanding access; IDLE always separates grants; abandoned
// accesses complete on the bus without a ready pulse to the requester.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   instr_address_in,
  input  logic                    instr_read_in,
  output logic [DATA_WIDTH-1:0]   instr_read_value_out,
  output logic                    instr_ready_out,
  input  logic [ADDR_WIDTH-1:0]   data_address_in,
  input  logic                    data_read_in,
  input  logic                    data_write_in,
  input  logic [DATA_WIDTH/8-1:0] data_write_mask_in,
  input  logic [DATA_WIDTH-1:0]   data_write_value_in,
  output logic [DATA_WIDTH-1:0]   data_read_value_out,
  output logic                    data_ready_out,
  output logic [ADDR_WIDTH-1:0]   bus_address_out,
  output logic                    bus_read_out,
  output logic                    bus_write_out,
  output logic [DATA_WIDTH/8-1:0] bus_write_mask_out,
  output logic [DATA_WIDTH-1:0]   bus_write_value_out,
  input  logic [DATA_WIDTH-1:0]   bus_read_value_in,
  input  logic                    bus_ready_in
);

  arb_state_t state_q, state_d;
  arb_grant_t grant;
  logic       any_req;
  logic       load_instr, load_data, done;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_instr(instr_read_in),
    .req_data (data_read_in | data_write_in),
    .update   (state_q == IDLE),
    .grant    (grant),
    .any_req  (any_req)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the load/complete strobes for the bus registers.
  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    load_data  = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (grant == GRANT_DATA) begin
            state_d   = DATA;
            load_data = 1'b1;
          end else begin
            state_d    = INSTR;
            load_instr = 1'b1;
          end
        end
      end
      INSTR, DATA: begin
        if (bus_ready_in) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request registers: latched on grant, frozen until the memory
  // completes, then only the strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_address_out     <= '0;
      bus_read_out        <= 1'b0;
      bus_write_out       <= 1'b0;
      bus_write_mask_out  <= '0;
      bus_write_value_out <= '0;
    end else if (load_instr) begin
      bus_address_out     <= instr_address_in;
      bus_read_out        <= 1'b1;
      bus_write_out       <= 1'b0;
      bus_write_mask_out  <= '0;
      bus_write_value_out <= '0;
    end else if (load_data) begin
      bus_address_out     <= data_address_in;
      bus_read_out        <= data_read_in;
      bus_write_out       <= data_write_in;
      bus_write_mask_out  <= data_write_mask_in;
      bus_write_value_out <= data_write_value_in;
    end else if (done) begin
      bus_read_out        <= 1'b0;
      bus_write_out       <= 1'b0;
    end
  end

  // A requester is acknowledged only if it still asks for exactly what was
  // issued; otherwise the completion is a silent drain.
  assign instr_ready_out = bus_ready_in && (state_q == INSTR) && instr_read_in
                           && (instr_address_in == bus_address_out);

  assign data_ready_out  = bus_ready_in && (state_q == DATA)
                           && (data_read_in | data_write_in)
                           && (data_address_in == bus_address_out)
                           && (data_read_in == bus_read_out)
                           && (data_write_in == bus_write_out);

  assign instr_read_value_out = bus_read_value_in;
  assign data_read_value_out  = bus_read_value_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a queue-based scoreboard: stimulus
// pushes expected bus accesses and ready pulses (with their cycle numbers),
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] instr_address_in = '0;
  logic          instr_read_in = 1'b0;
  logic [DW-1:0] instr_read_value_out;
  logic          instr_ready_out;
  logic [AW-1:0] data_address_in = '0;
  logic          data_read_in = 1'b0;
  logic          data_write_in = 1'b0;
  logic [MW-1:0] data_write_mask_in = '0;
  logic [DW-1:0] data_write_value_in = '0;
  logic [DW-1:0] data_read_value_out;
  logic          data_ready_out;
  logic [AW-1:0] bus_address_out;
  logic          bus_read_out;
  logic          bus_write_out;
  logic [MW-1:0] bus_write_mask_out;
  logic [DW-1:0] bus_write_value_out;
  logic [DW-1:0] bus_read_value_in = '0;
  logic          bus_ready_in = 1'b0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instr_address_in    (instr_address_in),
    .instr_read_in       (instr_read_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .data_address_in     (data_address_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .bus_address_out     (bus_address_out),
    .bus_read_out        (bus_read_out),
    .bus_write_out       (bus_write_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_read_value_in   (bus_read_value_in),
    .bus_ready_in        (bus_ready_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bus_req_t req;
    int       start_c;
    int       end_c;
  } exp_bus_t;

  typedef struct {
    logic [DW-1:0] value;
    int            c;
  } exp_rdy_t;

  exp_bus_t bus_q[$];
  exp_rdy_t instr_q[$];
  exp_rdy_t data_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic push_bus(input logic [AW-1:0] a, input logic rd, input logic wr,
                          input logic [MW-1:0] m, input logic [DW-1:0] v,
                          input int s, input int e);
    exp_bus_t x;
    x.req.address     = a;
    x.req.read        = rd;
    x.req.write       = wr;
    x.req.mask        = m;
    x.req.write_value = v;
    x.start_c         = s;
    x.end_c           = e;
    bus_q.push_back(x);
  endtask

  task automatic push_instr(input logic [DW-1:0] v, input int c);
    exp_rdy_t x;
    x.value = v;
    x.c     = c;
    instr_q.push_back(x);
  endtask

  task automatic push_data(input logic [DW-1:0] v, input int c);
    exp_rdy_t x;
    x.value = v;
    x.c     = c;
    data_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: tracks each bus access from first strobe to completion and
  // checks every ready pulse against the expectation queues.
  bus_req_t cur, start_req;
  int       start_c;
  bit       in_access = 1'b0;
  exp_bus_t eb;
  exp_rdy_t er;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_access = 1'b0;
    end else begin
      cur.address     = bus_address_out;
      cur.read        = bus_read_out;
      cur.write       = bus_write_out;
      cur.mask        = bus_write_mask_out;
      cur.write_value = bus_write_value_out;
      if (bus_read_out || bus_write_out) begin
        if (!in_access) begin
          in_access = 1'b1;
          start_req = cur;
          start_c   = cyc;
        end else begin
          check("bus_stable", 128'(cur), 128'(start_req));
        end
        if (bus_ready_in) begin
          if (bus_q.size() == 0) begin
            flag("bus_unexpected_access");
          end else begin
            eb = bus_q.pop_front();
            check("bus_fields", 128'(cur), 128'(eb.req));
            check("bus_start_cycle", 128'(start_c), 128'(eb.start_c));
            check("bus_end_cycle", 128'(cyc), 128'(eb.end_c));
          end
          in_access = 1'b0;
        end
      end else if (in_access) begin
        flag("bus_strobe_dropped_early");
        in_access = 1'b0;
      end

      if (instr_ready_out) begin
        if (instr_q.size() == 0) begin
          flag("instr_unexpected_ready");
        end else begin
          er = instr_q.pop_front();
          check("instr_value", 128'(instr_read_value_out), 128'(er.value));
          check("instr_ready_cycle", 128'(cyc), 128'(er.c));
        end
      end

      if (data_ready_out) begin
        if (data_q.size() == 0) begin
          flag("data_unexpected_ready");
        end else begin
          er = data_q.pop_front();
          check("data_value", 128'(data_read_value_out), 128'(er.value));
          check("data_ready_cycle", 128'(cyc), 128'(er.c));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_read"},  128'(bus_read_out), 128'(0));
    check({tag, "_bus_write"}, 128'(bus_write_out), 128'(0));
    check({tag, "_bus_addr"},  128'(bus_address_out), 128'(0));
    check({tag, "_bus_mask"},  128'(bus_write_mask_out), 128'(0));
    check({tag, "_bus_wval"},  128'(bus_write_value_out), 128'(0));
    check({tag, "_instr_rdy"}, 128'(instr_ready_out), 128'(0));
    check({tag, "_data_rdy"},  128'(data_ready_out), 128'(0));
  endtask

  int c0;
  int r;

  initial begin
    // Reset state.
    #2;
    check_all_zero("reset");
    step(2);
    rst_n = 1'b1;
    step(1);

    // Read data passes straight through; bus_ready_in in IDLE is ignored.
    bus_read_value_in = 32'h1357_2468;
    #1;
    check("passthru_instr", 128'(instr_read_value_out), 128'(32'h1357_2468));
    check("passthru_data",  128'(data_read_value_out),  128'(32'h1357_2468));
    bus_ready_in = 1'b1;
    step(1);
    bus_ready_in = 1'b0;
    step(1);
    check("idle_ready_no_strobe", 128'({bus_read_out, bus_write_out}), 128'(0));

    // Lone fetch of 0x100, memory ready three cycles later.
    c0 = cyc;
    instr_read_in    = 1'b1;
    instr_address_in = 32'h100;
    push_bus(32'h100, 1'b1, 1'b0, '0, '0, c0 + 1, c0 + 3);
    push_instr(32'hDEAD_BEEF, c0 + 3);
    step(3);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'hDEAD_BEEF;
    step(1);
    bus_ready_in  = 1'b0;
    instr_read_in = 1'b0;
    step(2);

    // Store with partial mask.
    c0 = cyc;
    data_write_in       = 1'b1;
    data_address_in     = 32'h2004;
    data_write_mask_in  = 4'b0011;
    data_write_value_in = 32'h1234;
    bus_read_value_in   = '0;
    push_bus(32'h2004, 1'b0, 1'b1, 4'b0011, 32'h1234, c0 + 1, c0 + 2);
    push_data('0, c0 + 2);
    step(2);
    bus_ready_in = 1'b1;
    step(1);
    bus_ready_in  = 1'b0;
    data_write_in = 1'b0;
    step(2);

    // Fresh reset so last_grant is INSTR; data must win the first tie.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);

    // Contention: both held, memory ready one cycle after the strobe.
    c0 = cyc;
    instr_read_in      = 1'b1;
    instr_address_in   = 32'h300;
    data_read_in       = 1'b1;
    data_address_in    = 32'h400;
    data_write_mask_in = '0;
    data_write_value_in = '0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_bus(32'h400, 1'b1, 1'b0, '0, '0, c0 + 1 + 3 * k, c0 + 2 + 3 * k);
        push_data(32'hA000_0000 + 32'(k), c0 + 2 + 3 * k);
      end else begin
        push_bus(32'h300, 1'b1, 1'b0, '0, '0, c0 + 1 + 3 * k, c0 + 2 + 3 * k);
        push_instr(32'hA000_0000 + 32'(k), c0 + 2 + 3 * k);
      end
    end
    step(2);
    for (int k = 0; k < 4; k++) begin
      bus_ready_in      = 1'b1;
      bus_read_value_in = 32'hA000_0000 + 32'(k);
      step(1);
      bus_ready_in = 1'b0;
      if (k == 3) begin
        instr_read_in = 1'b0;
        data_read_in  = 1'b0;
      end
      step(2);
    end

    // Flush drain: fetch of 0x40 abandoned, then a new fetch of 0x80.
    c0 = cyc;
    instr_read_in    = 1'b1;
    instr_address_in = 32'h40;
    push_bus(32'h40, 1'b1, 1'b0, '0, '0, c0 + 1, c0 + 4);
    step(2);
    instr_read_in = 1'b0;
    step(2);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h5555_5555;
    step(1);
    bus_ready_in     = 1'b0;
    instr_read_in    = 1'b1;
    instr_address_in = 32'h80;
    push_bus(32'h80, 1'b1, 1'b0, '0, '0, c0 + 6, c0 + 7);
    push_instr(32'h8080_8080, c0 + 7);
    step(2);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h8080_8080;
    step(1);
    bus_ready_in  = 1'b0;
    instr_read_in = 1'b0;
    step(2);

    // Address change mid-access: 0x40 drains silently, 0x80 reissued.
    c0 = cyc;
    instr_read_in    = 1'b1;
    instr_address_in = 32'h40;
    push_bus(32'h40, 1'b1, 1'b0, '0, '0, c0 + 1, c0 + 3);
    step(2);
    instr_address_in = 32'h80;
    step(1);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h0404_0404;
    step(1);
    bus_ready_in = 1'b0;
    push_bus(32'h80, 1'b1, 1'b0, '0, '0, c0 + 5, c0 + 6);
    push_instr(32'h0808_0808, c0 + 6);
    step(2);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h0808_0808;
    step(1);
    bus_ready_in  = 1'b0;
    instr_read_in = 1'b0;
    step(2);

    // Data type change mid-access (load becomes store): no ready for the
    // load, then the store is granted and completes at the earliest cycle.
    c0 = cyc;
    data_read_in        = 1'b1;
    data_address_in     = 32'h500;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    push_bus(32'h500, 1'b1, 1'b0, '0, '0, c0 + 1, c0 + 2);
    step(2);
    data_read_in        = 1'b0;
    data_write_in       = 1'b1;
    data_write_mask_in  = 4'hF;
    data_write_value_in = 32'h77;
    bus_ready_in        = 1'b1;
    bus_read_value_in   = 32'h1111_2222;
    step(1);
    bus_ready_in = 1'b0;
    push_bus(32'h500, 1'b0, 1'b1, 4'hF, 32'h77, c0 + 4, c0 + 4);
    push_data(32'h3333_4444, c0 + 4);
    step(1);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h3333_4444;
    step(1);
    bus_ready_in  = 1'b0;
    data_write_in = 1'b0;
    step(2);

    // Reset in the middle of a store; a pending fetch is served afterwards.
    c0 = cyc;
    data_write_in       = 1'b1;
    data_address_in     = 32'h600;
    data_write_mask_in  = 4'hC;
    data_write_value_in = 32'hAB;
    step(1);
    instr_read_in    = 1'b1;
    instr_address_in = 32'h700;
    step(1);
    rst_n        = 1'b0;
    bus_ready_in = 1'b1;
    #1;
    check_all_zero("midreset");
    data_write_in = 1'b0;
    step(1);
    rst_n        = 1'b1;
    bus_ready_in = 1'b0;
    r = cyc;
    push_bus(32'h700, 1'b1, 1'b0, '0, '0, r + 1, r + 1);
    push_instr(32'h600D_F00D, r + 1);
    step(1);
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h600D_F00D;
    step(1);
    bus_ready_in  = 1'b0;
    instr_read_in = 1'b0;
    step(3);

    check("bus_q_drained",   128'(bus_q.size()), 128'(0));
    check("instr_q_drained", 128'(instr_q.size()), 128'(0));
    check("data_q_drained",  128'(data_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory port between the fetch stage's instruction bus and the mem stage's data bus. Each requester sees its own read/ready (and write) handshake, so the hazard unit's `instr_ready` and `data_ready` inputs come directly from this block. Transactions are single-outstanding. Arbitration is round-robin on contention. In-flight transactions abandoned by a flushed requester are drained safely.

## Interface
- `ADDR_WIDTH`, default 32, width of all address ports.
- `DATA_WIDTH`, default 32, width of data ports. The mask width is `DATA_WIDTH/8`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `instr_address_in`  in  ADDR_WIDTH  fetch address.
- `instr_read_in`  in  1  fetch read request.
- `instr_read_value_out`  out  DATA_WIDTH  fetched word; valid while `instr_ready_out`=1.
- `instr_ready_out`  out  1  fetch transaction complete this cycle.
- `data_address_in`  in  ADDR_WIDTH  load/store address.
- `data_read_in`, `data_write_in`  in  1  load / store request; never both 1.
- `data_write_mask_in`  in  DATA_WIDTH/8  byte enables for stores.
- `data_write_value_in`  in  DATA_WIDTH  store data.
- `data_read_value_out`  out  DATA_WIDTH  load data; valid while `data_ready_out`=1.
- `data_ready_out`  out  1  data transaction complete this cycle.
- `bus_address_out`  out  ADDR_WIDTH  registered memory address.
- `bus_read_out`, `bus_write_out`  out  1  registered memory strobes.
- `bus_write_mask_out`  out  DATA_WIDTH/8  registered byte enables.
- `bus_write_value_out`  out  DATA_WIDTH  registered store data.
- `bus_read_value_in`  in  DATA_WIDTH  memory read data.
- `bus_ready_in`  in  1  memory completes the current access this cycle.

## Operation
- States: `IDLE`, `INSTR`, `DATA`.
- `IDLE`:
  - Samples requests. Only instr pending → `INSTR`. Only data pending → `DATA`.
  - Both pending → the requester not granted last time wins. The `last_grant` flag resets to INSTR, so data wins the first tie.
  - Entering a grant state latches address, strobes, mask and write value into the `bus_*_out` registers and updates `last_grant`.
- `INSTR`/`DATA`:
  - `bus_*_out` stay constant until `bus_ready_in`=1.
  - On that cycle: clear the bus strobes and return to `IDLE`.
- Requester ready, computed combinationally:
  - `instr_ready_out` = `bus_ready_in` && state==`INSTR` && `instr_read_in` && `instr_address_in`==latched address.
  - `data_ready_out` uses the same rule in `DATA`. It also requires the request type (read/write) to equal the latched type.
- Read values pass through combinationally: `*_read_value_out` = `bus_read_value_in`. This holds regardless of state; consumers qualify it with ready.
- Drain on abandon: if the granted requester drops or changes its request mid-transaction (branch flush), the bus access still completes unchanged. No ready pulse is given, and the FSM returns to `IDLE`. A new request is considered only from `IDLE`.
- The bus never sees a strobe deasserted before `bus_ready_in`, and never sees an address change mid-access.
- `bus_ready_in` in `IDLE` is ignored.

## Timing
- Reset values:
  - state=`IDLE`, `last_grant`=INSTR.
  - `bus_read_out`=`bus_write_out`=0; `bus_address_out`, `bus_write_mask_out`, `bus_write_value_out` = 0.
  - `instr_ready_out`=`data_ready_out`=0.
- Reset asserted mid-transaction aborts immediately to reset values. Memory tolerates strobe withdrawal on reset.
- Latency: request visible in cycle N (FSM in `IDLE`) → `bus_*_out` valid from cycle N+1 → requester ready in the cycle `bus_ready_in`=1, earliest N+1.
- Minimum 2 cycles per transaction, because `IDLE` always separates grants. Peak throughput is one access per 2 cycles.
- Requesters hold their request and operands stable until ready (hazard unit stalls guarantee this), except on flush.
- Simultaneous ready and new request from the other requester: the new request is sampled in the following `IDLE` cycle.

## Structure
- Shared package `bus_pkg`: state enum `arb_state_t` {IDLE, INSTR, DATA}, grant enum `arb_grant_t` {GRANT_INSTR, GRANT_DATA}, and a request struct `bus_req_t` {address, read, write, mask, write_value}.
- No sub-module required. An optional `rr_arbiter2` (2-input round-robin with `last_grant` register) is natural if the team wants to reuse it for the later DMA port.

## Test plan
- Lone fetch: `instr_read_in`=1, addr 0x100 at cycle 0; memory ready at cycle 3 with 0xDEADBEEF → `bus_read_out` cycles 1–3; `instr_ready_out`=1 and value 0xDEADBEEF only at cycle 3.
- Store: data write addr 0x2004, mask 0b0011, value 0x1234 → bus shows identical write fields cycle 1 until ready; `data_ready_out` pulses once; instr side gets no ready.
- Contention: both requesting continuously, memory ready 1 cycle after strobe → grants alternate DATA, INSTR, DATA, INSTR starting with DATA after reset.
- Flush drain: fetch granted addr 0x40, `instr_read_in` drops at cycle 2, ready at cycle 4 → bus holds 0x40 through cycle 4; no `instr_ready_out`; new fetch 0x80 issued on bus at cycle 6.
- Address change: fetch changes to 0x80 mid-access to 0x40 → no ready for the 0x40 completion; 0x80 issued as a fresh transaction afterwards.
- Reset mid-access: `rst_n` low during a `DATA` transaction → all outputs 0 asynchronously, state `IDLE`; after release, a pending fetch is granted first because `last_grant`=INSTR gives data priority only on a tie.
